// File: rtl/md_pad_responder_pkg.sv
// md_pad_pkg: shared constants and types for the Mega Drive pad responder.
//   BTN_*   : bit positions in the active-high joystick button word
//   PIN_*   : bit positions in the active-low pad_out pin word {p9,p6,p4,p3,p2,p1}
//   TIMEOUT_DEF : default select-inactivity timeout in clk cycles
//   md_btn_t / md_cnt_t : button word and phase counter types
package md_pad_pkg;

  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  localparam int PIN_P1 = 0;
  localparam int PIN_P2 = 1;
  localparam int PIN_P3 = 2;
  localparam int PIN_P4 = 3;
  localparam int PIN_P6 = 4;
  localparam int PIN_P9 = 5;

  localparam int TIMEOUT_DEF = 85000;

  typedef logic [11:0] md_btn_t;
  typedef logic [2:0]  md_cnt_t;

  // Increment that sticks at 4: phases past the extended-button read
  // keep returning normal data until the timeout clears the counter.
  function automatic md_cnt_t sat4(input md_cnt_t c);
    return (c >= 3'd4) ? 3'd4 : c + 3'd1;
  endfunction

endpackage

// File: rtl/md_pad_responder_if.sv
// md_pad_responder_if: pad-side bundle between the host/rig and the responder.
//   six_btn_en : 1 = 6-button protocol, 0 = 3-button pad
//   btn        : active-high buttons (md_pad_pkg BTN_* order)
//   pad_sel    : TH/select from host, asynchronous, idle high
//   pad_out    : active-low pins {p9,p6,p4,p3,p2,p1}
//   phase      : current cycle count 0..4
//   active     : select activity seen within the timeout window
// master = host/rig side, slave = the responder.
interface md_pad_responder_if;
  import md_pad_pkg::*;

  logic       six_btn_en;
  md_btn_t    btn;
  logic       pad_sel;
  logic [5:0] pad_out;
  logic [2:0] phase;
  logic       active;

  modport master (output six_btn_en, btn, pad_sel, input pad_out, phase, active);
  modport slave  (input six_btn_en, btn, pad_sel, output pad_out, phase, active);

endinterface

// File: rtl/md_pad_responder_sync.sv
// md_pad_sync: synchroniser for the asynchronous select line plus rising-edge
// detect on the synchronised value.
//   clk, reset : clock, synchronous active-high reset
//   sel_in     : raw asynchronous select
//   sel_s      : synchronised select (SYNC_STAGES flops, must be >= 2)
//   rise       : one-cycle pulse when sel_s goes 0 -> 1
module md_pad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sel_in,
  output logic sel_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sel_d;

  // Chain and delayed copy preset high to match the idle-high line, so
  // leaving reset never manufactures a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
      sel_d <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], sel_in};
      sel_d <= chain[SYNC_STAGES-1];
    end
  end

  assign sel_s = chain[SYNC_STAGES-1];
  assign rise  = sel_s & ~sel_d;

endmodule

// File: rtl/md_pad_responder.sv
// md_pad_responder: emulates a Mega Drive 3/6-button pad on the DB9 side.
// The host toggles TH/select; each synchronised rising edge advances a phase
// counter (0..4, saturating). Inactivity for TIMEOUT_CYC clocks returns the
// counter to 0. The registered pad_out is muxed from (select, phase) with
// pins driven low for pressed buttons.
//   clk   : system clock
//   reset : synchronous, active-high
//   pad   : slave side of md_pad_responder_if (buttons, select in; pins,
//           phase, active out)
module md_pad_responder
  import md_pad_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  md_pad_responder_if.slave   pad
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  logic          sel_s;
  logic          rise;
  md_cnt_t       cnt;
  logic [TW-1:0] timer;
  logic          active_q;
  logic [5:0]    pins_q;
  logic [5:0]    pins_nxt;
  logic          expired;
  md_btn_t       p;

  md_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sel_in (pad.pad_sel),
    .sel_s  (sel_s),
    .rise   (rise)
  );

  assign expired = (timer == TMR_LAST);

  // Timer stops at its last value once expired, so it cannot wrap and
  // produce a second expiry while select stays idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer    <= '0;
      active_q <= 1'b0;
    end else if (rise) begin
      timer    <= '0;
      active_q <= 1'b1;
    end else if (expired) begin
      active_q <= 1'b0;
    end else begin
      timer    <= timer + 1'b1;
    end
  end

  // Rise is checked before expiry so a coincident edge still advances.
  // The cnt>4 arm keeps the counter legal even if a select glitch is
  // captured inconsistently.
  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (!pad.six_btn_en) cnt <= '0;
    else if (rise)            cnt <= sat4(cnt);
    else if (expired)         cnt <= '0;
    else if (cnt > 3'd4)      cnt <= '0;
  end

  // Pins are high for released buttons.
  assign p = ~pad.btn;

  always_comb begin
    pins_nxt         = 6'h3F;
    pins_nxt[PIN_P9] = sel_s ? p[BTN_C] : p[BTN_START];
    pins_nxt[PIN_P6] = sel_s ? p[BTN_B] : p[BTN_A];
    if (sel_s) begin
      if (cnt == 3'd3) begin
        pins_nxt[PIN_P4] = p[BTN_MODE];
        pins_nxt[PIN_P3] = p[BTN_X];
        pins_nxt[PIN_P2] = p[BTN_Y];
        pins_nxt[PIN_P1] = p[BTN_Z];
      end else begin
        pins_nxt[PIN_P4] = p[BTN_R];
        pins_nxt[PIN_P3] = p[BTN_L];
        pins_nxt[PIN_P2] = p[BTN_D];
        pins_nxt[PIN_P1] = p[BTN_U];
      end
    end else begin
      case (cnt)
        // All four low is the 6-button identification.
        3'd2: pins_nxt[3:0] = 4'b0000;
        // All four high marks the phase following the extended read.
        3'd3: pins_nxt[3:0] = 4'b1111;
        // p4/p3 low identifies a Mega Drive pad to the host.
        default: begin
          pins_nxt[PIN_P4] = 1'b0;
          pins_nxt[PIN_P3] = 1'b0;
          pins_nxt[PIN_P2] = p[BTN_D];
          pins_nxt[PIN_P1] = p[BTN_U];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pins_q <= 6'h3F;
    else       pins_q <= pins_nxt;
  end

  assign pad.pad_out = pins_q;
  assign pad.phase   = cnt;
  assign pad.active  = active_q;

endmodule
